pipeline_mdu: RTL and testbench
===============================

Name: pipeline_mdu

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, placed beside the ALU in the EX stage of the five-stage core.
- Iterates STEP bits per cycle, so WIDTH and throughput trade off by parameter.
- Exposes a Start/Busy/Done handshake that the hazard unit uses to stall IF/ID/EX.
- Supports a Flush that cancels an in-flight operation on a branch or jump redirect.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even.
STEP, 1, quotient/product bits resolved per cycle; WIDTH % STEP == 0 (elaboration error otherwise).
CYC (derived, localparam), WIDTH/STEP, iteration cycles.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  issue request, qualified by Op
Op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (treated as no-op)
A  in  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO data)
B  in  WIDTH  rt operand (multiplier or divisor)
Flush  in  1  cancel in-flight op
Busy  out  1  unit occupied; hazard unit stalls any MDU or HI/LO-reading instruction
Done  out  1  one-cycle pulse: Hi/Lo updated at the preceding edge
DivByZero  out  1  one-cycle pulse coincident with Done for DIV/DIVU with B==0
Hi  out  WIDTH  HI register
Lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state): state=IDLE; Hi=0; Lo=0; Busy=0; Done=0; DivByZero=0; iteration counter=0.
- States:
  - IDLE: accepts Start.
  - RUN: CYC edges; processes STEP bits per edge.
  - FIX: one edge; applies sign correction and writes Hi/Lo; then returns to IDLE.
- Busy = (state != IDLE).
- Start in IDLE:
  - MULT/MULTU/DIV/DIVU: latch |A|, |B| (signed ops) or A, B (unsigned ops); record result signs; go to RUN.
  - MTHI/MTLO: write Hi or Lo at that edge; stay IDLE; no Done pulse.
  - Reserved Op: ignored.
- Start while Busy: ignored. The hazard unit guarantees this never happens; the assertion lives in the bench.
- Latency: Start accepted at edge 0 → Busy high for CYC+1 cycles → Hi/Lo written at edge CYC+1 → Done high for the cycle after.
  - WIDTH=32, STEP=1: 33 busy cycles.
  - Start is accepted in the Done cycle (back-to-back issue).
- Multiply:
  - Shift-add, 2*WIDTH product.
  - Hi = upper half, Lo = lower half.
  - Signed product is negated in FIX if the operand signs differ.
- Divide:
  - Restoring, STEP bits per cycle.
  - Lo = quotient, truncated toward zero.
  - Hi = remainder, carrying the sign of the dividend.
- Divide by zero: detected at Start.
  - Skips RUN; goes straight to FIX (2-cycle latency).
  - Hi = A, Lo = all ones, DivByZero pulses with Done.
- Signed overflow (A = most negative, B = -1): Lo = most negative, Hi = 0, full latency.
- Flush:
  - In RUN or FIX: return to IDLE at the next edge; Hi/Lo unchanged; no Done.
  - Flush with Start in the same cycle: Flush wins; the op is not accepted.
  - Flush in IDLE: no effect.
- Reset mid-operation: result discarded; Hi/Lo cleared.

Decomposition:
- Package mdu_pkg holds:
  - Op encodings MDU_MULT..MDU_MTLO.
  - State encoding IDLE/RUN/FIX.
  - Function for abs/negate of WIDTH-bit values.
- Sub-module mdu_step: combinational STEP-bit iteration.
  - Restoring subtract or conditional add, selected by mode.
  - Parametrised on WIDTH and STEP.
  - Instantiated once and fed by the RUN datapath registers.

Test Plan:
- Reset mid-RUN of MULT 5*7 → Hi=0, Lo=0, Busy=0 immediately; no Done.
- MULT A=-3 (0xFFFFFFFD), B=7 → after 33 busy cycles: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Done one cycle.
- DIV A=-7, B=2 → Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU A=100, B=7 → Lo=14, Hi=2.
- DIVU A=0x1234, B=0 → Done two cycles after Start; Hi=0x1234, Lo=0xFFFFFFFF, DivByZero pulsed. DIV A=0x80000000, B=-1 → Lo=0x80000000, Hi=0.
- MTHI 0xAAAA then MULTU 3*4; Flush at busy cycle 10 → Hi=0xAAAA retained, no Done; next MULTU 3*4 → Lo=12, Hi=0.
- STEP=4, WIDTH=16 build: MULTU 0xFFFF*0xFFFF → Hi=0xFFFE, Lo=0x0001 after 5 busy cycles; back-to-back Start in Done cycle accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and negate helper for the multiply/divide unit
package mdu_pkg;

    localparam int MDU_MAX_W = 128;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's-complement negate when en is set; callers zero-extend and truncate to their width.
    function automatic logic [MDU_MAX_W-1:0] mdu_negate(input logic [MDU_MAX_W-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

endpackage

// File: rtl/pipeline_mdu_if.sv
// rtl/pipeline_mdu_if.sv - issue/result bundle between the EX stage and the multiply/divide unit
interface pipeline_mdu_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (output Start, Op, A, B, Flush, input Busy, Done, DivByZero, Hi, Lo);
    modport slave  (input Start, Op, A, B, Flush, output Busy, Done, DivByZero, Hi, Lo);
endinterface

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - combinational STEP-bit iteration: restoring divide or shift-add multiply
module mdu_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH-1:0] h, l;
    logic [WIDTH:0]   t, d, s;

    // Divide: {h,l} = {remainder, dividend->quotient}. Multiply: {h,l} = {partial, multiplier->product low}.
    always_comb begin
        h = hi_in;
        l = lo_in;
        t = '0;
        d = '0;
        s = '0;
        for (int i = 0; i < STEP; i++) begin
            if (div_mode) begin
                t = {h, l[WIDTH-1]};
                l = {l[WIDTH-2:0], 1'b0};
                d = t - {1'b0, opnd};
                if (!d[WIDTH]) begin
                    h    = d[WIDTH-1:0];
                    l[0] = 1'b1;
                end else begin
                    h = t[WIDTH-1:0];
                end
            end else begin
                s = l[0] ? ({1'b0, h} + {1'b0, opnd}) : {1'b0, h};
                l = {s[0], l[WIDTH-1:1]};
                h = s[WIDTH:1];
            end
        end
        hi_out = h;
        lo_out = l;
    end

endmodule

// File: rtl/pipeline_mdu.sv
// rtl/pipeline_mdu.sv - multi-cycle multiply/divide unit with HI/LO registers and flush
module pipeline_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input logic           Clk,
    input logic           Reset,
    pipeline_mdu_if.slave bus
);

    localparam int CYC = WIDTH / STEP;
    localparam int CW  = $clog2(CYC + 1);
    localparam int W2  = 2 * WIDTH;

    if ((WIDTH % STEP) != 0 || (WIDTH % 2) != 0 || W2 > MDU_MAX_W) begin : g_bad_param
        $error("pipeline_mdu: WIDTH must be even, a multiple of STEP, and at most MDU_MAX_W/2");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, wrk_q, opnd_q, hi_q, lo_q, step_hi, step_lo;
    logic             is_div_q, neg_q, neg_rem_q, dbz_q, done_q, dbz_pulse_q;
    logic             accept, arith, signed_op, div_op, b_zero;

    assign accept    = bus.Start && !bus.Flush && (state_q == IDLE);
    assign arith     = (bus.Op == MDU_MULT) || (bus.Op == MDU_MULTU) || (bus.Op == MDU_DIV) || (bus.Op == MDU_DIVU);
    assign signed_op = (bus.Op == MDU_MULT) || (bus.Op == MDU_DIV);
    assign div_op    = (bus.Op == MDU_DIV) || (bus.Op == MDU_DIVU);
    assign b_zero    = (bus.B == '0);

    mdu_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .div_mode (is_div_q),
        .hi_in    (acc_q),
        .lo_in    (wrk_q),
        .opnd     (opnd_q),
        .hi_out   (step_hi),
        .lo_out   (step_lo)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && arith) state_d = (div_op && b_zero) ? FIX : RUN;
            RUN:     if (bus.Flush) state_d = IDLE;
                     else if (cnt_q == CW'(CYC - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            wrk_q       <= '0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            dbz_pulse_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            dbz_pulse_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    if (arith) begin
                        cnt_q     <= '0;
                        is_div_q  <= div_op;
                        neg_q     <= signed_op && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_rem_q <= signed_op && bus.A[WIDTH-1];
                        dbz_q     <= div_op && b_zero;
                        opnd_q    <= WIDTH'(mdu_negate(MDU_MAX_W'(bus.B), signed_op && bus.B[WIDTH-1]));
                        // Divide-by-zero parks its fixed result in the work registers for FIX.
                        if (div_op && b_zero) begin
                            acc_q <= bus.A;
                            wrk_q <= '1;
                        end else begin
                            acc_q <= '0;
                            wrk_q <= WIDTH'(mdu_negate(MDU_MAX_W'(bus.A), signed_op && bus.A[WIDTH-1]));
                        end
                    end else if (bus.Op == MDU_MTHI) begin
                        hi_q <= bus.A;
                    end else if (bus.Op == MDU_MTLO) begin
                        lo_q <= bus.A;
                    end
                end
                RUN: if (!bus.Flush) begin
                    acc_q <= step_hi;
                    wrk_q <= step_lo;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: if (!bus.Flush) begin
                    done_q      <= 1'b1;
                    dbz_pulse_q <= dbz_q;
                    if (dbz_q) begin
                        hi_q <= acc_q;
                        lo_q <= wrk_q;
                    end else if (is_div_q) begin
                        hi_q <= WIDTH'(mdu_negate(MDU_MAX_W'(acc_q), neg_rem_q));
                        lo_q <= WIDTH'(mdu_negate(MDU_MAX_W'(wrk_q), neg_q));
                    end else begin
                        {hi_q, lo_q} <= W2'(mdu_negate(MDU_MAX_W'({acc_q, wrk_q}), neg_q));
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_pulse_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;

endmodule

// File: tb/tb_pipeline_mdu.sv
// tb/tb_pipeline_mdu.sv - self-checking bench for pipeline_mdu (32x1 and 16x4 builds)
module tb_pipeline_mdu;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_hi32 = '0, exp_lo32 = '0;
    logic [31:0] exp_hi16 = '0, exp_lo16 = '0;

    always #5 clk = ~clk;

    pipeline_mdu_if #(.WIDTH(32)) m32 ();
    pipeline_mdu_if #(.WIDTH(16)) m16 ();

    pipeline_mdu #(.WIDTH(32), .STEP(1)) u32 (.Clk(clk), .Reset(rst), .bus(m32.slave));
    pipeline_mdu #(.WIDTH(16), .STEP(4)) u16 (.Clk(clk), .Reset(rst), .bus(m16.slave));

    // The hazard unit never issues into a busy unit; the bench holds itself to that.
    always @(posedge clk) begin
        if (m32.Start && !m32.Flush)
            assert (!m32.Busy) else begin errors++; $error("FAIL start_while_busy32 observed=1 expected=0"); end
        if (m16.Start && !m16.Flush)
            assert (!m16.Busy) else begin errors++; $error("FAIL start_while_busy16 observed=1 expected=0"); end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference results from plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, p, q, r, mask;
        longint unsigned ua, ub, up;
        mask = (longint'(1) << w) - 1;
        ua = 64'(a);
        ub = 64'(b);
        sa = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        dz = 1'b0; hi = '0; lo = '0;
        case (op)
            3'd0: begin p = sa * sb; hi = 32'((p >> w) & mask); lo = 32'(p & mask); end
            3'd1: begin up = ua * ub; hi = 32'((up >> w) & 64'(mask)); lo = 32'(up & 64'(mask)); end
            3'd2, 3'd3: begin
                if (ub == 0) begin dz = 1'b1; hi = a; lo = 32'(mask); end
                else if (op == 3'd2) begin q = sa / sb; r = sa % sb; hi = 32'(r & mask); lo = 32'(q & mask); end
                else begin hi = 32'(ua % ub); lo = 32'(ua / ub); end
            end
            default: ;
        endcase
    endfunction

    // Issues one op and, for arithmetic ops, returns in the Done cycle so the next call issues back-to-back.
    task automatic op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        ed;
        int          n;
        m32.Start = 1'b1; m32.Op = op; m32.A = a; m32.B = b;
        @(posedge clk); #1;
        m32.Start = 1'b0;
        if (op > 3'd3) begin
            if (op == 3'd4) exp_hi32 = a;
            if (op == 3'd5) exp_lo32 = a;
            chk("mt_busy32", 64'(m32.Busy), 64'd0);
            chk("mt_hi32", 64'(m32.Hi), 64'(exp_hi32));
            chk("mt_lo32", 64'(m32.Lo), 64'(exp_lo32));
            return;
        end
        model(32, op, a, b, eh, el, ed);
        n = 0;
        while (m32.Busy && n < 100) begin @(posedge clk); #1; n++; end
        chk("busy_cycles32", 64'(n), (op >= 3'd2 && b == 0) ? 64'd1 : 64'd33);
        chk("done32", 64'(m32.Done), 64'd1);
        chk("dbz32", 64'(m32.DivByZero), 64'(ed));
        chk("hi32", 64'(m32.Hi), 64'(eh));
        chk("lo32", 64'(m32.Lo), 64'(el));
        exp_hi32 = eh; exp_lo32 = el;
    endtask

    task automatic op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] eh, el;
        logic        ed;
        int          n;
        m16.Start = 1'b1; m16.Op = op; m16.A = a; m16.B = b;
        @(posedge clk); #1;
        m16.Start = 1'b0;
        model(16, op, 32'(a), 32'(b), eh, el, ed);
        n = 0;
        while (m16.Busy && n < 100) begin @(posedge clk); #1; n++; end
        chk("busy_cycles16", 64'(n), (op >= 3'd2 && b == 0) ? 64'd1 : 64'd5);
        chk("done16", 64'(m16.Done), 64'd1);
        chk("dbz16", 64'(m16.DivByZero), 64'(ed));
        chk("hi16", 64'(m16.Hi), 64'(eh));
        chk("lo16", 64'(m16.Lo), 64'(el));
    endtask

    initial begin
        int cnt;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1;
        m32.Start = 0; m32.Op = 0; m32.A = 0; m32.B = 0; m32.Flush = 0;
        m16.Start = 0; m16.Op = 0; m16.A = 0; m16.B = 0; m16.Flush = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(m32.Busy), 64'd0);
        chk("rst_done", 64'(m32.Done), 64'd0);
        chk("rst_dbz", 64'(m32.DivByZero), 64'd0);
        chk("rst_hi", 64'(m32.Hi), 64'd0);
        chk("rst_lo", 64'(m32.Lo), 64'd0);
        chk("rst_hilo16", 64'({m16.Hi, m16.Lo}), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Asynchronous reset in the middle of a MULT discards it and clears HI/LO.
        op32(3'd4, 32'h55, 32'h0);
        m32.Start = 1'b1; m32.Op = 3'd0; m32.A = 32'd5; m32.B = 32'd7;
        @(posedge clk); #1; m32.Start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; #1;
        chk("midrst_busy", 64'(m32.Busy), 64'd0);
        chk("midrst_hi", 64'(m32.Hi), 64'd0);
        chk("midrst_lo", 64'(m32.Lo), 64'd0);
        exp_hi32 = '0; exp_lo32 = '0;
        @(negedge clk) rst = 1'b0;
        cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (m32.Done) cnt++; end
        chk("midrst_no_done", 64'(cnt), 64'd0);

        // Directed arithmetic, including divide-by-zero and signed overflow, issued back-to-back.
        op32(3'd0, 32'hFFFF_FFFD, 32'd7);
        op32(3'd2, 32'hFFFF_FFF9, 32'd2);
        op32(3'd3, 32'd100, 32'd7);
        op32(3'd3, 32'h1234, 32'd0);
        op32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("done_pulse_width", 64'(m32.Done), 64'd0);
        chk("dbz_pulse_width", 64'(m32.DivByZero), 64'd0);

        // Flush during RUN leaves HI/LO untouched and suppresses Done.
        op32(3'd4, 32'hAAAA, 32'h0);
        m32.Start = 1'b1; m32.Op = 3'd1; m32.A = 32'd3; m32.B = 32'd4;
        @(posedge clk); #1; m32.Start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        m32.Flush = 1'b1;
        @(posedge clk); #1; m32.Flush = 1'b0;
        chk("flush_busy", 64'(m32.Busy), 64'd0);
        cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (m32.Done) cnt++; end
        chk("flush_no_done", 64'(cnt), 64'd0);
        chk("flush_hi", 64'(m32.Hi), 64'(exp_hi32));
        chk("flush_lo", 64'(m32.Lo), 64'(exp_lo32));
        op32(3'd1, 32'd3, 32'd4);

        // Flush wins over a same-cycle Start; reserved ops do nothing.
        m32.Start = 1'b1; m32.Flush = 1'b1; m32.Op = 3'd1; m32.A = 32'd9; m32.B = 32'd9;
        @(posedge clk); #1; m32.Start = 1'b0; m32.Flush = 1'b0;
        chk("start_flush_busy", 64'(m32.Busy), 64'd0);
        op32(3'd6, 32'h1111, 32'h2222);
        op32(3'd7, 32'h3333, 32'h4444);

        // Randomized ops against the reference model, mixing back-to-back and gapped issue.
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            op32(rop, ra, rb);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                chk("rand_done_low", 64'(m32.Done), 64'd0);
            end
        end

        // 16-bit, 4-bits-per-cycle build.
        op16(3'd1, 16'hFFFF, 16'hFFFF);
        op16(3'd3, 16'd1000, 16'd7);
        for (int i = 0; i < 10; i++)
            op16(3'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom));
        @(posedge clk); #1;
        chk("done16_low", 64'(m16.Done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
